csrs: RTL and testbench

// - Machine-mode CSR file for the multi-cycle RV32 core (IFU->IDU->EXU->LSU->WBU).
// - IDU side: combinational read port, with trap-vector / return-address override for ecall/mret.
// - WBU side: commits CSR writes and trap side effects on the cycle WBU retires an instruction.
// - Implements mstatus, mtvec, mepc and mcause, plus read-only mvendorid and marchid.

---
 rtl/core_pkg.sv | 24 ++
 rtl/csrs.sv | 82 ++++++++
 tb/tb_csrs.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: CSR address map, reset values and trap cause codes.
package core_pkg;

    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [ADDR_WIDTH-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [ADDR_WIDTH-1:0] CSR_MEPC      = 12'h341;
    localparam logic [ADDR_WIDTH-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [ADDR_WIDTH-1:0] CSR_MVENDORID = 12'hF11;
    localparam logic [ADDR_WIDTH-1:0] CSR_MARCHID   = 12'hF12;

    localparam logic [DATA_WIDTH-1:0] MCAUSE_ECALL_M = 32'd11;
    localparam logic [DATA_WIDTH-1:0] MSTATUS_RESET  = 32'h0000_1800;
    localparam logic [DATA_WIDTH-1:0] MVENDORID_VAL  = 32'h7973_7978;
    localparam logic [DATA_WIDTH-1:0] MARCHID_VAL    = 32'h0000_0000;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csrs.sv
// Machine-mode CSR file: combinational IDU read port with ecall/mret vector override,
// WBU-side commit of CSR writes and trap side effects.
module csrs
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_WIDTH,
    parameter int unsigned DATA_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_wbu,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wen,
    input  logic              is_ecall_wbu,
    input  logic              is_mret_wbu,
    input  logic [DATA_W-1:0] pc,
    input  logic              is_ecall_idu,
    input  logic              is_mret_idu,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] mstatus;
    logic [DATA_W-1:0] mtvec;
    logic [DATA_W-1:0] mepc;
    logic [DATA_W-1:0] mcause;

    // M-only core: MPP is hardwired to machine mode on every update path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus <= DATA_W'(MSTATUS_RESET);
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (valid_wbu) begin
            if (is_ecall_wbu) begin
                mepc                                   <= pc;
                mcause                                 <= DATA_W'(MCAUSE_ECALL_M);
                mstatus[MSTATUS_MPIE]                  <= mstatus[MSTATUS_MIE];
                mstatus[MSTATUS_MIE]                   <= 1'b0;
                mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
            end else if (is_mret_wbu) begin
                mstatus[MSTATUS_MIE]                   <= mstatus[MSTATUS_MPIE];
                mstatus[MSTATUS_MPIE]                  <= 1'b1;
                mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
            end else if (wen) begin
                case (waddr)
                    CSR_MSTATUS: begin
                        mstatus                                <= wdata;
                        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
                    end
                    CSR_MTVEC:  mtvec  <= wdata;
                    CSR_MEPC:   mepc   <= wdata;
                    CSR_MCAUSE: mcause <= wdata;
                    default: ;
                endcase
            end
        end
    end

    // Read mux; no bypass of a same-cycle write.
    always_comb begin
        data = '0;
        if (is_ecall_idu) begin
            data = mtvec;
        end else if (is_mret_idu) begin
            data = mepc;
        end else begin
            case (raddr)
                CSR_MSTATUS:   data = mstatus;
                CSR_MTVEC:     data = mtvec;
                CSR_MEPC:      data = mepc;
                CSR_MCAUSE:    data = mcause;
                CSR_MVENDORID: data = DATA_W'(MVENDORID_VAL);
                CSR_MARCHID:   data = DATA_W'(MARCHID_VAL);
                default:       data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_csrs.sv
// Directed self-checking bench for the machine-mode CSR file.
module tb_csrs;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_wbu;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        wen;
    logic        is_ecall_wbu;
    logic        is_mret_wbu;
    logic [31:0] pc;
    logic        is_ecall_idu;
    logic        is_mret_idu;
    logic [11:0] raddr;
    logic [31:0] data;

    int n_vec = 0;
    int n_err = 0;

    csrs dut (
        .clk          (clk),
        .rst          (rst),
        .valid_wbu    (valid_wbu),
        .waddr        (waddr),
        .wdata        (wdata),
        .wen          (wen),
        .is_ecall_wbu (is_ecall_wbu),
        .is_mret_wbu  (is_mret_wbu),
        .pc           (pc),
        .is_ecall_idu (is_ecall_idu),
        .is_mret_idu  (is_mret_idu),
        .raddr        (raddr),
        .data         (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        valid_wbu    = 1'b0;
        wen          = 1'b0;
        waddr        = '0;
        wdata        = '0;
        is_ecall_wbu = 1'b0;
        is_mret_wbu  = 1'b0;
        pc           = '0;
        is_ecall_idu = 1'b0;
        is_mret_idu  = 1'b0;
        raddr        = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        is_ecall_idu = 1'b0;
        is_mret_idu  = 1'b0;
        raddr        = a;
        #1;
        check(tag, data, exp);
    endtask

    task automatic wr(input logic v, input logic [11:0] a, input logic [31:0] d);
        valid_wbu = v;
        wen       = 1'b1;
        waddr     = a;
        wdata     = d;
        tick();
        idle();
    endtask

    initial begin
        idle();
        // reset with garbage on the commit inputs
        rst = 1'b0;
        valid_wbu = 1'b1; wen = 1'b1; waddr = 12'h305; wdata = 32'hFFFF_FFFF;
        tick();
        rst = 1'b1;
        idle();
        rd("rst_mstatus",   12'h300, 32'h0000_1800);
        rd("rst_mtvec",     12'h305, 32'h0);
        rd("rst_mepc",      12'h341, 32'h0);
        rd("rst_mcause",    12'h342, 32'h0);
        rd("rst_mvendorid", 12'hF11, 32'h7973_7978);
        rd("rst_marchid",   12'hF12, 32'h0);
        rd("rst_unmapped",  12'h123, 32'h0);

        // mret from reset state: MIE<=MPIE(0), MPIE<=1
        valid_wbu = 1'b1; is_mret_wbu = 1'b1;
        tick(); idle();
        rd("mret_from_rst", 12'h300, 32'h0000_1880);

        // write gating
        wr(1'b1, 12'h305, 32'h8000_0100);
        rd("mtvec_wr", 12'h305, 32'h8000_0100);
        wr(1'b0, 12'h305, 32'hDEAD_BEEF);
        rd("mtvec_novalid", 12'h305, 32'h8000_0100);

        // mstatus write keeps MPP=11
        wr(1'b1, 12'h300, 32'h0000_0008);
        rd("mstatus_warl", 12'h300, 32'h0000_1808);
        wr(1'b1, 12'h341, 32'hFFFF_FFFF);
        rd("mepc_full", 12'h341, 32'hFFFF_FFFF);

        // ecall wins over a simultaneous mepc write
        valid_wbu = 1'b1; is_ecall_wbu = 1'b1; pc = 32'h8000_0040;
        wen = 1'b1; waddr = 12'h341; wdata = 32'h0000_1234;
        tick(); idle();
        rd("ecall_mepc",    12'h341, 32'h8000_0040);
        rd("ecall_mcause",  12'h342, 32'd11);
        rd("ecall_mstatus", 12'h300, 32'h0000_1880);
        is_ecall_idu = 1'b1; raddr = 12'h342; #1;
        check("idu_ecall_vec", data, 32'h8000_0100);
        is_mret_idu = 1'b1; #1;
        check("idu_both_prio", data, 32'h8000_0100);
        idle();

        // gated ecall does nothing
        valid_wbu = 1'b0; is_ecall_wbu = 1'b1; pc = 32'h0000_0444;
        tick(); idle();
        rd("ecall_novalid", 12'h341, 32'h8000_0040);

        // mret wins over a simultaneous mepc write
        valid_wbu = 1'b1; is_mret_wbu = 1'b1;
        wen = 1'b1; waddr = 12'h341; wdata = 32'h0000_5555;
        tick(); idle();
        rd("mret_mstatus", 12'h300, 32'h0000_1888);
        rd("mret_mepc",    12'h341, 32'h8000_0040);
        rd("mret_mcause",  12'h342, 32'd11);
        is_mret_idu = 1'b1; raddr = 12'h300; #1;
        check("idu_mret_epc", data, 32'h8000_0040);
        idle();

        // read-only and unmapped writes
        wr(1'b1, 12'hF11, 32'h1111_2222);
        rd("mvendorid_ro", 12'hF11, 32'h7973_7978);
        wr(1'b1, 12'hF12, 32'h3333_4444);
        rd("marchid_ro", 12'hF12, 32'h0);
        wr(1'b1, 12'h7C0, 32'h5555_6666);
        rd("unmapped_wr", 12'h7C0, 32'h0);

        // same-cycle read/write returns the old value
        valid_wbu = 1'b1; wen = 1'b1; waddr = 12'h342; wdata = 32'h0000_CAFE;
        raddr = 12'h342; #1;
        check("rw_old", data, 32'd11);
        tick();
        valid_wbu = 1'b0; wen = 1'b0; #1;
        check("rw_new", data, 32'h0000_CAFE);
        idle();

        // reset beats a simultaneous ecall commit
        rst = 1'b0;
        valid_wbu = 1'b1; is_ecall_wbu = 1'b1; pc = 32'h8000_0080;
        tick();
        rst = 1'b1;
        idle();
        rd("rst2_mstatus", 12'h300, 32'h0000_1800);
        rd("rst2_mtvec",   12'h305, 32'h0);
        rd("rst2_mepc",    12'h341, 32'h0);
        rd("rst2_mcause",  12'h342, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
